lower_mem_responder: RTL and testbench
======================================

# lower_mem_responder

- Main-memory end of the shared coherence bus: the responder for cache-initiated BusRd/BusRdX line fills and Mem_wr write-backs.
- Sits below the cache wrappers on Address_Com/Data_Bus_Com and requests bus ownership from the arbiter (Mem_snoop_req/Mem_snoop_gnt) before driving read data.
- Holds a word-addressed backing store with a per-word valid bit, so unwritten locations return deterministic data.

## Interface
- ADDRESSSIZE, 32: address and data width.
- MEM_DEPTH, 1024: number of words; index = Address_Com[$clog2(MEM_DEPTH)-1:0], upper bits ignored (aliasing).
- READ_LATENCY, 4: cycles from read acceptance to Mem_snoop_req; legal range ≥1.
- WRITE_LATENCY, 4: cycles from write acceptance to Mem_write_done; legal range ≥1.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- BusRd  in  1  read-miss request; a level held by the requester until it has taken the data.
- BusRdX  in  1  read-for-ownership request; same handshake as BusRd.
- Mem_wr  in  1  write-back request; a level held until Mem_write_done.
- Mem_oprn_abort  in  1  a peer cache supplies the line, so the pending read is cancelled.
- Address_Com  in  ADDRESSSIZE  bus address.
- Data_Bus_Com  inout  ADDRESSSIZE  bus data; driven only in RD_DRIVE, otherwise Z.
- Mem_snoop_req  out  1  bus request to the arbiter.
- Mem_snoop_gnt  in  1  arbiter grant.
- Data_in_Bus  out  1  tri-state; 1 in RD_DRIVE, otherwise Z (shared with snooping caches).
- Mem_write_done  out  1  write completion.

## Operation
- States:
  - IDLE
  - RD_WAIT
  - RD_REQ
  - RD_DRIVE
  - RD_ABORT
  - WR_WAIT
  - WR_DONE
- IDLE:
  - Mem_wr high: capture Address_Com and Data_Bus_Com, load counter = WRITE_LATENCY, go to WR_WAIT. Mem_wr has priority over BusRd/BusRdX in the same cycle.
  - Otherwise, BusRd or BusRdX high: capture Address_Com, load counter = READ_LATENCY, go to RD_WAIT.
- RD_WAIT: counter decrements each cycle; at 1, go to RD_REQ.
- RD_REQ: Mem_snoop_req=1; when Mem_snoop_gnt is sampled high, go to RD_DRIVE.
- RD_DRIVE:
  - Mem_snoop_req=1, Data_in_Bus=1.
  - Data_Bus_Com carries mem[idx] if valid[idx] is set, else the captured address.
  - Stays until BusRd and BusRdX are both low, then returns to IDLE.
- Abort: Mem_oprn_abort sampled high in RD_WAIT or RD_REQ moves to RD_ABORT and drops Mem_snoop_req. Abort is ignored in RD_DRIVE.
- RD_ABORT: drives nothing; returns to IDLE once BusRd and BusRdX are both low. This prevents re-acceptance of a still-held request.
- WR_WAIT: counter decrements; at 1, write mem[idx], set valid[idx], go to WR_DONE.
- WR_DONE: Mem_write_done=1 until Mem_wr is sampled low, then IDLE.
- Reset (asserted at any time, including mid-operation):
  - state → IDLE; counter → 0; all valid bits cleared.
  - Mem_snoop_req=0, Mem_write_done=0; Data_in_Bus and Data_Bus_Com=Z.
  - No partial write commits.

## Timing
- Read acceptance at edge N (IDLE samples BusRd). Mem_snoop_req rises after edge N+READ_LATENCY.
- Grant sampled at edge G puts data on Data_Bus_Com, with Data_in_Bus=1, after G.
- Minimum read-to-data with immediate grant: READ_LATENCY+1 cycles.
- Write accepted at edge N: array updated and Mem_write_done high after edge N+WRITE_LATENCY.
- Data captured for a write is the Data_Bus_Com value at the acceptance edge, not later.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- Counter width is $clog2(max(READ_LATENCY,WRITE_LATENCY))+1.

## Configuration
- LOWER_MEM_ABORT_EN:
  - Defined: Mem_oprn_abort handling and the RD_ABORT state are compiled in, as described above.
  - Undefined: Mem_oprn_abort is ignored, RD_ABORT does not exist, and every accepted read proceeds to RD_DRIVE.

## Test plan
- Reset, then BusRd with Address_Com=0x0000_0040 held → Mem_snoop_req rises after 4 cycles. After the grant, Data_Bus_Com=0x0000_0040 and Data_in_Bus=1. Releasing BusRd leaves both at Z.
- Mem_wr with Address_Com=0x10, Data_Bus_Com=0xDEADBEEF → Mem_write_done after 4 cycles. A following BusRdX to 0x10 returns 0xDEADBEEF.
- Mem_wr and BusRd asserted in the same cycle → the write completes first, then the read is served (BusRd still held).
- With LOWER_MEM_ABORT_EN: BusRd, then Mem_oprn_abort in the 2nd wait cycle → Mem_snoop_req never rises and the bus stays Z. No new read starts until BusRd drops.
- Grant withheld 10 cycles → Mem_snoop_req stays 1 and the bus stays Z until the grant. Data appears the cycle after the grant.
- rst pulsed during WR_WAIT for address 0x20 → all outputs reset immediately. A later read of 0x20 returns 0x0000_0020, proving valid bits were cleared and the write was not committed.

Source files
------------

// File: rtl/lower_mem_responder.sv
// lower_mem_responder
//   Main-memory end of the shared coherence bus. Serves BusRd/BusRdX line
//   fills and Mem_wr write-backs from a word-addressed backing store.
//   Each word has a valid bit. A word that has never been written reads back
//   as the captured request address, so the result is deterministic.
//
// Ports
//   clk             system clock, all state updates on posedge
//   rst             asynchronous active-high reset
//   BusRd, BusRdX   read requests, held by the requester until data taken
//   Mem_wr          write-back request, held until Mem_write_done
//   Mem_oprn_abort  peer cache supplies the line; cancels a pending read
//   Address_Com     bus address
//   Data_Bus_Com    bidirectional bus data; driven only while serving a read
//   Mem_snoop_req   bus ownership request to the arbiter
//   Mem_snoop_gnt   arbiter grant
//   Data_in_Bus     tri-state flag, 1 while this block drives Data_Bus_Com
//   Mem_write_done  write completion
//
// Build option
//   LOWER_MEM_ABORT_EN: when defined, Mem_oprn_abort cancels reads in
//   RD_WAIT/RD_REQ through the RD_ABORT state. When undefined, the abort
//   input is ignored.

module lower_mem_responder #(
    parameter int ADDRESSSIZE   = 32,
    parameter int MEM_DEPTH     = 1024,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   BusRd,
    input  logic                   BusRdX,
    input  logic                   Mem_wr,
    input  logic                   Mem_oprn_abort,
    input  logic [ADDRESSSIZE-1:0] Address_Com,
    inout  wire  [ADDRESSSIZE-1:0] Data_Bus_Com,
    output logic                   Mem_snoop_req,
    input  logic                   Mem_snoop_gnt,
    output wire                    Data_in_Bus,
    output logic                   Mem_write_done
);

    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_REQ,
        RD_DRIVE,
`ifdef LOWER_MEM_ABORT_EN
        RD_ABORT,
`endif
        WR_WAIT,
        WR_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDRESSSIZE-1:0]  addr_q, addr_d;
    logic [ADDRESSSIZE-1:0]  wdata_q, wdata_d;
    logic                    mem_we;

    logic [ADDRESSSIZE-1:0]  mem_q [MEM_DEPTH];
    logic [MEM_DEPTH-1:0]    valid_q;
    logic [ADDRESSSIZE-1:0]  rd_word_q;
    logic                    rd_valid_q;
    logic [IDX_W-1:0]        idx;
    logic                    drive;

    assign idx = addr_q[IDX_W-1:0];

`ifndef LOWER_MEM_ABORT_EN
    logic unused_abort;
    assign unused_abort = Mem_oprn_abort;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                // A write-back wins over a simultaneous read request.
                if (Mem_wr) begin
                    addr_d  = Address_Com;
                    wdata_d = Data_Bus_Com;
                    cnt_d   = CNT_W'(WRITE_LATENCY);
                    state_d = WR_WAIT;
                end else if (BusRd || BusRdX) begin
                    addr_d  = Address_Com;
                    cnt_d   = CNT_W'(READ_LATENCY);
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
`ifdef LOWER_MEM_ABORT_EN
                if (Mem_oprn_abort) begin
                    state_d = RD_ABORT;
                end else
`endif
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
`ifdef LOWER_MEM_ABORT_EN
                if (Mem_oprn_abort) begin
                    state_d = RD_ABORT;
                end else
`endif
                if (Mem_snoop_gnt) begin
                    state_d = RD_DRIVE;
                end
            end
            RD_DRIVE: begin
                if (!BusRd && !BusRdX) begin
                    state_d = IDLE;
                end
            end
`ifdef LOWER_MEM_ABORT_EN
            // Wait for the requester to drop its level so the same request
            // is not accepted a second time.
            RD_ABORT: begin
                if (!BusRd && !BusRdX) begin
                    state_d = IDLE;
                end
            end
`endif
            WR_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    mem_we  = 1'b1;
                    state_d = WR_DONE;
                end
            end
            WR_DONE: begin
                if (!Mem_wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            valid_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_valid_q <= valid_q[idx];
            if (mem_we) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    // The data array has no reset. A word only becomes visible through its
    // valid bit, and reset clears every valid bit.
    // The read port is registered every cycle from the captured index. The
    // result is always settled before RD_DRIVE is reached.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
        rd_word_q <= mem_q[idx];
    end

    assign drive          = (state_q == RD_DRIVE);
    assign Mem_snoop_req  = (state_q == RD_REQ) || (state_q == RD_DRIVE);
    assign Mem_write_done = (state_q == WR_DONE);
    assign Data_in_Bus    = drive ? 1'b1 : 1'bz;
    assign Data_Bus_Com   = drive ? (rd_valid_q ? rd_word_q : addr_q)
                                  : {ADDRESSSIZE{1'bz}};

endmodule

// File: tb/tb_lower_mem_responder.sv
module tb_lower_mem_responder;

    localparam int DEPTH = 1024;
    localparam int RL    = 4;
    localparam int WL    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        BusRd = 1'b0, BusRdX = 1'b0, Mem_wr = 1'b0;
    logic        abort = 1'b0, gnt = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] bus_val = '0;
    logic        bus_en = 1'b0;
    wire  [31:0] data_bus;
    wire         din_bus;
    logic        req, done;
    logic        drv;

    assign data_bus = bus_en ? bus_val : 32'bz;
    assign drv      = (din_bus === 1'b1);

    always #5 clk = ~clk;

    lower_mem_responder dut (
        .clk            (clk),
        .rst            (rst),
        .BusRd          (BusRd),
        .BusRdX         (BusRdX),
        .Mem_wr         (Mem_wr),
        .Mem_oprn_abort (abort),
        .Address_Com    (addr),
        .Data_Bus_Com   (data_bus),
        .Mem_snoop_req  (req),
        .Mem_snoop_gnt  (gnt),
        .Data_in_Bus    (din_bus),
        .Mem_write_done (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference store: an entry exists only for words written since reset.
    logic [31:0] mem_m [int];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expected_read(input logic [31:0] a);
        int key;
        key = int'(a % DEPTH);
        return mem_m.exists(key) ? mem_m[key] : a;
    endfunction

    // Called at a negedge while the DUT is idle; returns at a negedge, idle.
    task automatic do_read(input logic [31:0] a, input int gwait, input bit rdx,
                           input int hold, input bit abort_in_drive);
        logic [31:0] exp;
        exp = expected_read(a);
        addr = a;
        if (rdx) BusRdX = 1'b1; else BusRd = 1'b1;
        for (int i = 0; i < RL; i++) begin
            @(negedge clk);
            addr = $urandom;   // the captured address must be used
            check_eq("rd_req_early", {31'b0, req}, 32'd0);
            check_eq("rd_drive_early", {31'b0, drv}, 32'd0);
        end
        @(negedge clk);
        check_eq("rd_req_rise", {31'b0, req}, 32'd1);
        for (int i = 0; i < gwait; i++) begin
            check_eq("rd_req_hold", {31'b0, req}, 32'd1);
            check_eq("rd_drive_before_gnt", {31'b0, drv}, 32'd0);
            @(negedge clk);
        end
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        check_eq("rd_drive", {31'b0, drv}, 32'd1);
        check_eq("rd_data", data_bus, exp);
        abort = abort_in_drive;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("rd_drive_hold", {31'b0, drv}, 32'd1);
            check_eq("rd_data_hold", data_bus, exp);
            check_eq("rd_req_drive", {31'b0, req}, 32'd1);
        end
        abort = 1'b0;
        BusRd  = 1'b0;
        BusRdX = 1'b0;
        @(negedge clk);
        check_eq("rd_release_drive", {31'b0, drv}, 32'd0);
        check_eq("rd_release_req", {31'b0, req}, 32'd0);
        $display("read  addr=0x%08h rdx=%0d gnt_wait=%0d data=0x%08h expect=0x%08h",
                 a, rdx, gwait, data_bus, exp);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit hold_rd);
        addr    = a;
        bus_val = d;
        bus_en  = 1'b1;
        Mem_wr  = 1'b1;
        if (hold_rd) BusRd = 1'b1;
        for (int i = 0; i < WL; i++) begin
            @(negedge clk);
            bus_val = ~d;        // data after acceptance must not be captured
            addr    = $urandom;
            check_eq("wr_done_early", {31'b0, done}, 32'd0);
            check_eq("wr_req_quiet", {31'b0, req}, 32'd0);
        end
        @(negedge clk);
        check_eq("wr_done", {31'b0, done}, 32'd1);
        mem_m[int'(a % DEPTH)] = d;
        Mem_wr = 1'b0;
        bus_en = 1'b0;
        @(negedge clk);
        check_eq("wr_done_drop", {31'b0, done}, 32'd0);
        check_eq("wr_then_idle_req", {31'b0, req}, 32'd0);
        $display("write addr=0x%08h data=0x%08h hold_rd=%0d", a, d, hold_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] up;
        logic [31:0] a;
        logic [9:0]  lo;

        #1 rst = 1'b1;
        #1;
        check_eq("reset_req", {31'b0, req}, 32'd0);
        check_eq("reset_done", {31'b0, done}, 32'd0);
        check_eq("reset_drive", {31'b0, drv}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Unwritten word returns its address.
        do_read(32'h0000_0040, 0, 1'b0, 2, 1'b0);
        // Write then read back with BusRdX; aliased address hits the same word.
        do_write(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        do_read(32'h0000_0010, 1, 1'b1, 1, 1'b0);
        do_read(32'h0000_0410, 0, 1'b0, 0, 1'b0);
        // Write and read requested together: write first, then the held read.
        do_write(32'h0000_0030, 32'h1234_5678, 1'b1);
        do_read(32'h0000_0030, 0, 1'b0, 1, 1'b0);
        // Grant withheld for 10 cycles; abort during RD_DRIVE is ignored.
        do_read(32'h0000_0040, 10, 1'b0, 2, 1'b1);

`ifdef LOWER_MEM_ABORT_EN
        addr  = 32'h0000_0080;
        BusRd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check_eq("abort_req", {31'b0, req}, 32'd0);
            check_eq("abort_drive", {31'b0, drv}, 32'd0);
            @(negedge clk);
        end
        BusRd = 1'b0;
        @(negedge clk);
        check_eq("abort_idle_req", {31'b0, req}, 32'd0);
        $display("abort addr=0x00000080 req_stayed_low");
        do_read(32'h0000_0080, 0, 1'b0, 0, 1'b0);
`else
        // Without the abort feature the input is ignored throughout.
        abort = 1'b1;
        do_read(32'h0000_0080, 0, 1'b0, 0, 1'b1);
        abort = 1'b0;
`endif

        // Reset in the middle of a write: nothing commits, valid bits clear.
        addr    = 32'h0000_0020;
        bus_val = 32'hCAFE_F00D;
        bus_en  = 1'b1;
        Mem_wr  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_done", {31'b0, done}, 32'd0);
        check_eq("midrst_req", {31'b0, req}, 32'd0);
        check_eq("midrst_drive", {31'b0, drv}, 32'd0);
        @(negedge clk);
        Mem_wr = 1'b0;
        bus_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_m.delete();
        for (int i = 0; i < WL + 2; i++) begin
            @(negedge clk);
            check_eq("midrst_no_done", {31'b0, done}, 32'd0);
        end
        $display("reset during write addr=0x00000020");
        do_read(32'h0000_0020, 0, 1'b0, 0, 1'b0);
        do_read(32'h0000_0010, 0, 1'b1, 0, 1'b0);

        // Randomized mix over a small pool of words with random upper bits.
        for (int t = 0; t < 40; t++) begin
            up = $urandom;
            lo = 10'(32'h100 + 8 * $urandom_range(0, 7));
            a  = {up[31:10], lo};
            if ($urandom_range(0, 2) == 0) begin
                do_write(a, $urandom, 1'b0);
            end else begin
                do_read(a, $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 2), 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
